// File: rtl/pdf_pkg.sv
// Shared encodings for the post-detection window filter.
// Mode and FSM state encodings plus the legal window-size bounds.
package pdf_pkg;

    typedef enum logic [1:0] {
        MODE_MEAN = 2'b00,
        MODE_MAJ  = 2'b01,
        MODE_BYP  = 2'b10,
        MODE_RSV  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int TAP_LOG2_MIN = 1;
    localparam int TAP_LOG2_MAX = 4;

endpackage

// File: rtl/pdf_tap_line.sv
// N-deep sample delay line with whole-line preload; exposes the oldest tap.
// Updates in one cycle when shift or preload is asserted; holds otherwise.
module pdf_tap_line #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic              i_shift,
    input  logic              i_preload,
    input  logic [DATA_W-1:0] i_dat,
    output logic [DATA_W-1:0] o_oldest
);

    logic [DATA_W-1:0] r_taps [DEPTH];

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
        end else if (i_preload) begin
            for (int i = 0; i < DEPTH; i++) r_taps[i] <= i_dat;
        end else if (i_shift) begin
            r_taps[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
        end
    end

    assign o_oldest = r_taps[DEPTH-1];

endmodule

// File: rtl/post_detection_window_filter.sv
// Sliding-window mean / majority / bypass filter over a line of edge pixels.
// One enabled cycle in_valid -> out_valid; no backpressure, enb=0 freezes all state.
module post_detection_window_filter
    import pdf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TAP_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enb,
    input  logic                in_valid,
    input  logic                in_sol,
    input  logic [DATA_W-1:0]   in_pixel,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   thresh,
    input  logic [TAP_LOG2:0]   maj_k,
    output logic                out_valid,
    output logic                out_sol,
    output logic [DATA_W-1:0]   out_pixel
);

    localparam int N     = 1 << TAP_LOG2;
    localparam int SUM_W = DATA_W + TAP_LOG2;
    localparam int CNT_W = TAP_LOG2 + 1;

    if (TAP_LOG2 < TAP_LOG2_MIN || TAP_LOG2 > TAP_LOG2_MAX) begin : g_bad_tap_log2
        $error("TAP_LOG2 out of legal range");
    end

    state_e             r_state;
    logic [SUM_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_out_sol;
    logic [DATA_W-1:0]  r_out_pixel;

    logic               w_accept;
    logic               w_preload;
    logic               w_shift;
    logic               w_hit;
    logic [DATA_W:0]    w_oldest;
    logic [SUM_W-1:0]   w_sum_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  w_pix_nxt;

    assign w_accept  = enb & in_valid;
    assign w_preload = w_accept & (in_sol | (r_state == ST_IDLE));
    assign w_shift   = w_accept & ~w_preload;
    assign w_hit     = (in_pixel >= thresh);

    // Each tap carries its own hit bit so a mid-line thresh change never
    // corrupts the running count when that tap is later evicted.
    pdf_tap_line #(
        .DATA_W (DATA_W + 1),
        .DEPTH  (N)
    ) u_tap_line (
        .clk       (clk),
        .i_reset_n (reset),
        .i_shift   (w_shift),
        .i_preload (w_preload),
        .i_dat     ({w_hit, in_pixel}),
        .o_oldest  (w_oldest)
    );

    always_comb begin
        w_sum_nxt = '0;
        w_cnt_nxt = '0;
        if (w_preload) begin
            w_sum_nxt = {in_pixel, {TAP_LOG2{1'b0}}};
            w_cnt_nxt = w_hit ? {1'b1, {TAP_LOG2{1'b0}}} : '0;
        end else begin
            w_sum_nxt = r_sum + {{TAP_LOG2{1'b0}}, in_pixel}
                              - {{TAP_LOG2{1'b0}}, w_oldest[DATA_W-1:0]};
            w_cnt_nxt = r_cnt + {{TAP_LOG2{1'b0}}, w_hit}
                              - {{TAP_LOG2{1'b0}}, w_oldest[DATA_W]};
        end
    end

    always_comb begin
        w_pix_nxt = in_pixel;
        case (mode)
            MODE_MEAN: w_pix_nxt = w_sum_nxt[SUM_W-1:TAP_LOG2];
            MODE_MAJ:  w_pix_nxt = (w_cnt_nxt >= maj_k) ? '1 : '0;
            default:   w_pix_nxt = in_pixel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sol   <= 1'b0;
            r_out_pixel <= '0;
        end else begin
            r_out_valid <= w_accept;
            r_out_sol   <= w_accept & in_sol;
            if (w_accept) begin
                r_state     <= ST_RUN;
                r_sum       <= w_sum_nxt;
                r_cnt       <= w_cnt_nxt;
                r_out_pixel <= w_pix_nxt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sol   = r_out_sol;
    assign out_pixel = r_out_pixel;

endmodule

// File: tb/tb_post_detection_window_filter.sv
// Directed bench for the window filter (DATA_W=8, TAP_LOG2=2).
module tb_post_detection_window_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic       in_valid;
    logic       in_sol;
    logic [7:0] in_pixel;
    logic [1:0] mode;
    logic [7:0] thresh;
    logic [2:0] maj_k;
    logic       out_valid;
    logic       out_sol;
    logic [7:0] out_pixel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    post_detection_window_filter #(
        .DATA_W   (8),
        .TAP_LOG2 (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .in_valid  (in_valid),
        .in_sol    (in_sol),
        .in_pixel  (in_pixel),
        .mode      (mode),
        .thresh    (thresh),
        .maj_k     (maj_k),
        .out_valid (out_valid),
        .out_sol   (out_sol),
        .out_pixel (out_pixel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic s, input logic [7:0] p);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".sol"},   {31'd0, out_sol},   {31'd0, s});
        chk({tag, ".pixel"}, {24'd0, out_pixel}, {24'd0, p});
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic drive(input logic e, input logic v, input logic s, input logic [7:0] p);
        enb      = e;
        in_valid = v;
        in_sol   = s;
        in_pixel = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; enb = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_pixel = '0;
        mode = 2'b00; thresh = 8'd128; maj_k = 3'd3;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            mode = 2'($urandom_range(0, 3));
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            chk_out("reset", 1'b0, 1'b0, 8'd0);
        end
        reset = 1'b1;
        mode  = 2'b00;

        // Mean ramp
        drive(1, 1, 1, 8'd100); chk_out("mean0", 1, 1, 8'd100);
        drive(1, 1, 0, 8'd200); chk_out("mean1", 1, 0, 8'd125);
        drive(1, 1, 0, 8'd200); chk_out("mean2", 1, 0, 8'd150);
        drive(1, 1, 0, 8'd200); chk_out("mean3", 1, 0, 8'd175);
        drive(1, 1, 0, 8'd200); chk_out("mean4", 1, 0, 8'd200);

        // Same ramp with a mid-line stall
        drive(1, 1, 1, 8'd100); chk_out("stl0", 1, 1, 8'd100);
        drive(1, 1, 0, 8'd200); chk_out("stl1", 1, 0, 8'd125);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'(i % 2), 1'(i % 2), 8'hAA);
            chk_out("stall", 0, 0, 8'd125);
        end
        drive(1, 1, 0, 8'd200); chk_out("stl2", 1, 0, 8'd150);
        drive(1, 1, 0, 8'd200); chk_out("stl3", 1, 0, 8'd175);
        drive(1, 1, 0, 8'd200); chk_out("stl4", 1, 0, 8'd200);

        // Line of 250s, then a new SOL must not leak old samples
        drive(1, 1, 1, 8'd250); chk_out("l250a", 1, 1, 8'd250);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 8'd250);
            chk_out("l250", 1, 0, 8'd250);
        end
        drive(1, 1, 1, 8'd40);  chk_out("sol40", 1, 1, 8'd40);
        drive(1, 1, 0, 8'd80);  chk_out("win80", 1, 0, 8'd50);

        // Reset mid-line, first sample after release preloads
        reset = 1'b0;
        drive(1, 1, 0, 8'd99);  chk_out("midrst", 0, 0, 8'd0);
        reset = 1'b1;
        drive(1, 1, 0, 8'd60);  chk_out("post60", 1, 0, 8'd60);

        // Idle cycle holds pixel; SOL without valid is ignored
        drive(1, 0, 1, 8'd7);   chk_out("idle", 0, 0, 8'd60);
        drive(1, 1, 0, 8'd100); chk_out("nosol", 1, 0, 8'd70);

        // Majority, then maj_k=0
        mode = 2'b01; thresh = 8'd128; maj_k = 3'd3;
        drive(1, 1, 1, 8'd255); chk_out("maj0", 1, 1, 8'd255);
        drive(1, 1, 0, 8'd0);   chk_out("maj1", 1, 0, 8'd255);
        drive(1, 1, 0, 8'd0);   chk_out("maj2", 1, 0, 8'd0);
        maj_k = 3'd0;
        drive(1, 1, 0, 8'd0);   chk_out("majk0", 1, 0, 8'd255);

        // Bypass and reserved mode, then back to mean without flush
        mode = 2'b10;
        drive(1, 1, 0, 8'd17);  chk_out("byp", 1, 0, 8'd17);
        mode = 2'b11;
        drive(1, 1, 0, 8'd33);  chk_out("rsv", 1, 0, 8'd33);
        mode = 2'b00;
        drive(1, 1, 0, 8'd0);   chk_out("remean", 1, 0, 8'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/post_detection_window_filter.md
POST_DETECTION_WINDOW_FILTER -- requirements
Module: post_detection_window_filter

Interface
REQ-001 Parameter DATA_W, default 8, pixel bit width.
REQ-002 Parameter TAP_LOG2, default 2, legal 1..4; window N = 2^TAP_LOG2 samples.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 enb  input  1  clock enable; low = full stall.
REQ-006 in_valid  input  1  in_pixel valid this cycle.
REQ-007 in_sol  input  1  start-of-line marker, qualified by in_valid.
REQ-008 in_pixel  input  DATA_W  edge-detected pixel.
REQ-009 mode  input  2  00 mean, 01 majority, 10 bypass, 11 reserved (treated as bypass).
REQ-010 thresh  input  DATA_W  majority hit threshold.
REQ-011 maj_k  input  TAP_LOG2+1  majority hit count required.
REQ-012 out_valid  output  1  out_pixel valid.
REQ-013 out_sol  output  1  registered copy of in_sol for the output sample.
REQ-014 out_pixel  output  DATA_W  filtered pixel.

Function
REQ-015 All outputs SHALL be registered; latency in_valid -> out_valid SHALL be exactly 1 enabled cycle.
REQ-016 FSM SHALL have states IDLE (no line active) and RUN (line active).
REQ-017 IDLE -> RUN on any accepted sample (enb & in_valid); RUN stays RUN; only reset returns to IDLE.
REQ-018 An accepted sample with in_sol=1, or any accepted sample in IDLE, SHALL preload all N taps with in_pixel (edge replication), sum = in_pixel*N, hit count = N or 0 per thresh.
REQ-019 Otherwise an accepted sample SHALL shift into the N-tap line, evicting the oldest tap.
REQ-020 Running sum SHALL be DATA_W+TAP_LOG2 bits, updated sum + new - oldest, never overflowing.
REQ-021 Mean mode: out_pixel = (updated sum) >> TAP_LOG2, truncating; window includes the current sample.
REQ-022 Hit = (tap >= thresh); running hit count TAP_LOG2+1 bits, updated + new_hit - oldest_hit.
REQ-023 Majority mode: out_pixel = all-ones if updated hit count >= maj_k, else 0; maj_k=0 gives all-ones.
REQ-024 Bypass mode: out_pixel = in_pixel of the accepted sample; taps, sum and hit count SHALL still update.
REQ-025 mode, thresh, maj_k SHALL be sampled on the accepting cycle; changes mid-line take effect on the next output without flushing.
REQ-026 enb=0: taps, sum, count, state and out_pixel SHALL hold; out_valid and out_sol SHALL be 0.
REQ-027 enb=1, in_valid=0: state holds; out_valid=0, out_sol=0, out_pixel holds.
REQ-028 in_sol with in_valid=0 SHALL be ignored.

Reset
REQ-029 reset=0 at a clock edge SHALL clear taps, sum, hit count, out_pixel, out_valid, out_sol to 0 and set state IDLE, regardless of enb.
REQ-030 Reset mid-line SHALL discard the line; the first accepted sample after release preloads per REQ-018.

Structure
REQ-031 Package pdf_pkg SHALL hold mode encodings, FSM state encodings and TAP_LOG2 legal bounds.
REQ-032 The delay line SHALL be a sub-module pdf_tap_line (parametrised DATA_W, depth N; shift, preload, oldest-tap output).
REQ-033 Sum, hit count, FSM and output mux SHALL live in the top module; no dividers or multipliers (preload sum by shift).

Verification (DATA_W=8, TAP_LOG2=2)
REQ-034 reset=0 for 3 cycles with random inputs -> out_valid=0, out_sol=0, out_pixel=0 every cycle.
REQ-035 Mean: SOL 100, then 200,200,200,200 -> out_pixel 100,125,150,175,200, out_sol on first only.
REQ-036 Mean: mid-line enb=0 for 4 cycles with toggling in_valid -> out_valid=0, out_pixel held; resuming sequence values identical to unstalled run.
REQ-037 Majority thresh=128, maj_k=3: SOL 255, then 0, 0 -> out_pixel 255, 255, 0.
REQ-038 Mean: after line of 250s, SOL 40 -> out_pixel 40 next cycle (no leakage); reset=0 mid-line -> outputs 0, first sample after release 60 -> out_pixel 60.
